// File: rtl/fc_ctrl_pkg.sv
// Shared types and helpers for the fully-connected MAC lane sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fc_ctrl_pkg;

   typedef enum logic [1:0] {
      S_LOAD    = 2'd0,
      S_COMPUTE = 2'd1,
      S_DRAIN   = 2'd2,
      S_OUTPUT  = 2'd3
   } state_t;

   // Address width for a memory of the given depth; never narrower than one bit.
   function automatic int addr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/mac_ctrl_delay_line.sv
// Shift register carrying one issue bit per cycle down the MAC pipeline.
// Latency: tap_first 1 cycle, tap_mid DEPTH-1 cycles, tap_last DEPTH cycles.
// Backpressure: none; shifts every cycle, so the MAC pipeline never stalls.
module mac_ctrl_delay_line #(
   parameter int DEPTH = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic issue,
   output logic tap_first,
   output logic tap_mid,
   output logic tap_last,
   output logic busy
);

   logic [DEPTH-1:0] chain;

   // Shift issue bits toward the accumulator end; reset drops any in-flight terms.
   always_ff @(posedge clk) begin
      if (reset) chain <= '0;
      else       chain <= {chain[DEPTH-2:0], issue};
   end

   assign tap_first = chain[0];
   assign tap_mid   = chain[DEPTH-2];
   assign tap_last  = chain[DEPTH-1];
   assign busy      = |chain;

endmodule

// File: rtl/fc_mac_seq_ctrl.sv
// Sequencer: loads x, issues N x/w reads per row, drives MAC enables, emits M dot products.
// Latency: first issue to output_valid = N + P + 2 cycles; next row issues the cycle after acceptance.
// Backpressure: input_ready only in S_LOAD; S_OUTPUT holds with all enables low until output_ready.
module fc_mac_seq_ctrl
   import fc_ctrl_pkg::*;
#(
   parameter  int M  = 4,
   parameter  int N  = 4,
   parameter  int T  = 14,
   parameter  int P  = 2,
   localparam int XW = addr_width(N),
   localparam int WW = addr_width(M * N)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          input_valid,
   output logic          input_ready,
   output logic [XW-1:0] addr_x,
   output logic          wr_en_x,
   output logic [WW-1:0] addr_w,
   output logic          enable_mult,
   output logic          en_pipeline_reg,
   output logic          en_acc,
   output logic          clear_acc,
   input  logic [T-1:0]  f,
   output logic [T-1:0]  output_data,
   output logic          output_valid,
   input  logic          output_ready
);

   localparam int            MW     = addr_width(M);
   localparam logic [XW-1:0] N_LAST = XW'(N - 1);
   localparam logic [MW-1:0] M_LAST = MW'(M - 1);

   state_t        state, state_nxt;
   logic [XW-1:0] n, n_nxt;
   logic [MW-1:0] m, m_nxt;
   logic [WW-1:0] addr_w_nxt;
   logic          issue;
   logic          busy;

   // Issue bits travel P+1 deep: multiplier, product register, accumulator taps.
   mac_ctrl_delay_line #(.DEPTH(P + 1)) u_delay (
      .clk       (clk),
      .reset     (reset),
      .issue     (issue),
      .tap_first (enable_mult),
      .tap_mid   (en_pipeline_reg),
      .tap_last  (en_acc),
      .busy      (busy)
   );

   // State and counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= S_LOAD;
         n      <= '0;
         m      <= '0;
         addr_w <= '0;
      end else begin
         state  <= state_nxt;
         n      <= n_nxt;
         m      <= m_nxt;
         addr_w <= addr_w_nxt;
      end
   end

   // Next-state, counter updates and state-decoded handshake outputs.
   always_comb begin
      state_nxt    = state;
      n_nxt        = n;
      m_nxt        = m;
      addr_w_nxt   = addr_w;
      issue        = 1'b0;
      input_ready  = 1'b0;
      output_valid = 1'b0;
      case (state)
         S_LOAD: begin
            input_ready = 1'b1;
            if (input_valid) begin
               if (n == N_LAST) begin
                  n_nxt      = '0;
                  m_nxt      = '0;
                  addr_w_nxt = '0;
                  state_nxt  = S_COMPUTE;
               end else begin
                  n_nxt = n + XW'(1);
               end
            end
         end
         S_COMPUTE: begin
            issue = 1'b1;
            if (n == N_LAST) begin
               n_nxt     = '0;
               state_nxt = S_DRAIN;
               // After the final term of the final row wrap to 0 so addr_w never reaches M*N.
               addr_w_nxt = (m == M_LAST) ? '0 : addr_w + WW'(1);
            end else begin
               n_nxt      = n + XW'(1);
               addr_w_nxt = addr_w + WW'(1);
            end
         end
         S_DRAIN: begin
            // Empty chain means the last accumulate has landed in f.
            if (!busy) state_nxt = S_OUTPUT;
         end
         S_OUTPUT: begin
            output_valid = 1'b1;
            if (output_ready) begin
               n_nxt = '0;
               if (m == M_LAST) begin
                  m_nxt     = '0;
                  state_nxt = S_LOAD;
               end else begin
                  m_nxt     = m + MW'(1);
                  state_nxt = S_COMPUTE;
               end
            end
         end
         default: state_nxt = S_LOAD;
      endcase
   end

   assign addr_x      = n;
   assign wr_en_x     = input_valid && input_ready;
   assign clear_acc   = output_valid && output_ready;
   assign output_data = f;

endmodule

// File: tb/tb_fc_mac_seq_ctrl.sv
// Directed bench: drives the sequencer with a behavioural x/w memory + saturating MAC datapath.
// Latency: checks N+P+2 row latency and zero-bubble row turnaround.
// Backpressure: exercises output_ready low, input_valid gaps and mid-row reset.
module tb_fc_mac_seq_ctrl;

   localparam int M  = 4;
   localparam int N  = 3;
   localparam int T  = 14;
   localparam int P  = 2;
   localparam int XW = 2;
   localparam int WW = 4;
   localparam int ROW_LAT = N + P + 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          input_valid;
   logic          input_ready;
   logic [XW-1:0] addr_x;
   logic          wr_en_x;
   logic [WW-1:0] addr_w;
   logic          enable_mult;
   logic          en_pipeline_reg;
   logic          en_acc;
   logic          clear_acc;
   logic [T-1:0]  f;
   logic [T-1:0]  output_data;
   logic          output_valid;
   logic          output_ready;

   int checks = 0;
   int errors = 0;
   int viol   = 0;
   int prev_aw = 0;
   int addr_log[$];
   int xv[N];
   int exp_v[M];

   logic signed [T-1:0] in_dat;
   logic signed [T-1:0] x_mem[N];
   logic signed [T-1:0] w_mem[M*N];
   logic signed [T-1:0] a_q, b_q, acc;
   logic signed [2*T-1:0] mul_q, prod_q;

   fc_mac_seq_ctrl #(.M(M), .N(N), .T(T), .P(P)) dut (
      .clk             (clk),
      .reset           (reset),
      .input_valid     (input_valid),
      .input_ready     (input_ready),
      .addr_x          (addr_x),
      .wr_en_x         (wr_en_x),
      .addr_w          (addr_w),
      .enable_mult     (enable_mult),
      .en_pipeline_reg (en_pipeline_reg),
      .en_acc          (en_acc),
      .clear_acc       (clear_acc),
      .f               (f),
      .output_data     (output_data),
      .output_valid    (output_valid),
      .output_ready    (output_ready)
   );

   always #5 clk = ~clk;

   function automatic logic signed [T-1:0] sat(input logic signed [2*T+1:0] v);
      if (v > 8191)       return 14'sd8191;
      else if (v < -8192) return -14'sd8192;
      else                return v[T-1:0];
   endfunction

   // Datapath model: registered-read memories, one multiplier stage, product reg, saturating acc.
   always @(posedge clk) begin
      if (wr_en_x) x_mem[addr_x] <= in_dat;
      a_q <= x_mem[addr_x];
      b_q <= w_mem[addr_w];
      if (reset) begin
         mul_q  <= '0;
         prod_q <= '0;
         acc    <= '0;
      end else begin
         if (enable_mult)     mul_q  <= (2*T)'(a_q) * (2*T)'(b_q);
         if (en_pipeline_reg) prod_q <= mul_q;
         if (clear_acc)       acc    <= '0;
         else if (en_acc)     acc    <= sat((2*T+2)'(acc) + (2*T+2)'(prod_q));
      end
   end
   assign f = acc;

   // Invariant tracking and issued-address log, sampled away from the clock edge.
   always @(negedge clk) begin
      if (!reset) begin
         if (en_acc && clear_acc) viol++;
         if (int'(addr_w) >= M*N) viol++;
         if (enable_mult) addr_log.push_back(prev_aw);
      end
      prev_aw = int'(addr_w);
   end

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Stream xv into the x memory; with gaps, input_valid toggles 1,0,1,0,1.
   task automatic load_x(input bit gaps);
      int idx = 0;
      for (int k = 0; idx < N && k < 20; k++) begin
         logic vld;
         vld = gaps ? (k % 2 == 0) : 1'b1;
         input_valid = vld;
         in_dat = T'(xv[idx]);
         #1;
         if (gaps) begin
            chk("load_wr_en", int'(wr_en_x), int'(vld));
            chk("load_ready", int'(input_ready), 1);
            if (vld) chk($sformatf("load_addr_x%0d", idx), int'(addr_x), idx);
         end
         tick();
         if (vld) idx++;
      end
      input_valid = 1'b0;
      #1;
      chk("load_done_ready_low", int'(input_ready), 0);
   endtask

   // Run all M rows starting at the first issue cycle; bp_row holds output_ready low 10 cycles.
   task automatic run_layer(input int bp_row);
      addr_log.delete();
      for (int r = 0; r < M; r++) begin
         int cnt = 0;
         chk($sformatf("row%0d_addr_w_start", r), int'(addr_w), r * N);
         output_ready = (r != bp_row);
         while (!output_valid && cnt < 50) begin
            tick();
            cnt++;
         end
         chk($sformatf("row%0d_latency", r), cnt, ROW_LAT);
         chk($sformatf("row%0d_data", r), int'($signed(output_data)), exp_v[r]);
         if (r == bp_row) begin
            int bad = 0;
            for (int k = 0; k < 10; k++) begin
               tick();
               if (!output_valid || int'($signed(output_data)) != exp_v[r]) bad++;
               if (enable_mult || en_pipeline_reg || en_acc || clear_acc) bad++;
            end
            chk("bp_hold", bad, 0);
            output_ready = 1'b1;
            #1;
         end
         chk($sformatf("row%0d_clear", r), int'(clear_acc), 1);
         tick();
         chk($sformatf("row%0d_clear_pulse", r), int'(clear_acc), 0);
      end
      chk("back_to_load", int'(input_ready), 1);
      chk("aw_count", addr_log.size(), M * N);
      for (int i = 0; i < addr_log.size() && i < M * N; i++)
         chk($sformatf("aw_seq%0d", i), addr_log[i], i);
   endtask

   task automatic set_row(input int r, input int w0, input int w1, input int w2);
      w_mem[r*N+0] = T'(w0);
      w_mem[r*N+1] = T'(w1);
      w_mem[r*N+2] = T'(w2);
   endtask

   initial begin
      reset        = 1'b1;
      input_valid  = 1'b0;
      output_ready = 1'b1;
      in_dat       = '0;
      for (int i = 0; i < N; i++) x_mem[i] = '0;
      set_row(0, 4, 5, 6);
      set_row(1, 1, 1, 1);
      set_row(2, -1, -2, -3);
      set_row(3, 10, 0, -2);
      repeat (3) tick();
      chk("rst_input_ready", int'(input_ready), 1);
      chk("rst_output_valid", int'(output_valid), 0);
      chk("rst_enables", int'({enable_mult, en_pipeline_reg, en_acc, clear_acc}), 0);
      chk("rst_addr_x", int'(addr_x), 0);
      chk("rst_addr_w", int'(addr_w), 0);
      reset = 1'b0;
      tick();

      // Layer 1: gapped load of {1,2,3}, backpressure on row 1.
      xv = '{1, 2, 3};
      exp_v = '{32, 6, -14, 4};
      load_x(1'b1);
      run_layer(1);

      // Layer 2: saturation; the accumulator clamps after every term.
      // Row 3: 81910->8191, +0, -16382 -> -8191.
      xv = '{8191, 8191, 8191};
      set_row(0, 8191, 8191, 8191);
      set_row(1, -8191, -8191, -8191);
      exp_v = '{8191, -8192, -8192, -8191};
      load_x(1'b0);
      run_layer(-1);

      // Reset during drain of row 0, then a clean full run.
      set_row(0, 4, 5, 6);
      set_row(1, 1, 1, 1);
      xv = '{1, 2, 3};
      exp_v = '{32, 6, -14, 4};
      load_x(1'b0);
      repeat (4) tick();
      chk("drain_acc_active", int'(en_acc), 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      chk("abort_input_ready", int'(input_ready), 1);
      chk("abort_output_valid", int'(output_valid), 0);
      chk("abort_chain", int'({enable_mult, en_pipeline_reg, en_acc}), 0);
      load_x(1'b0);
      run_layer(-1);

      chk("acc_clear_overlap_or_aw_range", viol, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
